bitwise_logic_pipe: RTL and testbench

- Parametrised, two-stage pipelined bitwise logic unit.
- Supports eight operations on WIDTH-bit operands: NOT, AND, OR, XOR, NAND, NOR, XNOR and PASS.
- Uses valid/ready handshakes on input and output, optional result flags, and a completed-transaction counter.
- Sits beside the ALU datapath as the logic-operation execution unit, replacing the fixed 32-bit combinational inverter.

---
 rtl/bitwise_logic_pipe.sv | 138 +++++++++++++
 tb/tb_bitwise_logic_pipe.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe: two-stage valid/ready bitwise logic unit (NOT..PASS) with a
// completed-transfer counter. Define BITWISE_LOGIC_FLAGS_EN for zero/ones/parity flags.
module bitwise_logic_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
    output logic [CNT_W-1:0] op_count
);

    function automatic logic [WIDTH-1:0] logic_op(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [2:0]       op);
        logic [WIDTH-1:0] r;
        case (op)
            3'd0:    r = ~a;
            3'd1:    r = a & b;
            3'd2:    r = a | b;
            3'd3:    r = a ^ b;
            3'd4:    r = ~(a & b);
            3'd5:    r = ~(a | b);
            3'd6:    r = ~(a ^ b);
            3'd7:    r = a;
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    logic             s1_valid_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       op_r;
    logic             s2_valid_r;
    logic [WIDTH-1:0] result_r;
    logic [CNT_W-1:0] count_r;
    logic             s2_free_s;
    logic             in_fire_s;
    logic             move_s;
    logic             out_fire_s;
    logic [WIDTH-1:0] result_s;

    // Handshake decode; in_ready sees out_ready combinationally so a draining S2 frees S1.
    always_comb begin
        s2_free_s  = !s2_valid_r || out_ready;
        in_ready   = !s1_valid_r || s2_free_s;
        in_fire_s  = in_valid && in_ready;
        move_s     = s1_valid_r && s2_free_s;
        out_fire_s = s2_valid_r && out_ready;
        result_s   = logic_op(a_r, b_r, op_r);
    end

    // Stage 1 capture: an item held here is only replaced once it moves on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            op_r       <= 3'd0;
        end else if (in_fire_s) begin
            s1_valid_r <= 1'b1;
            a_r        <= in_a;
            b_r        <= in_b;
            op_r       <= in_op;
        end else if (move_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: result register, loaded only from a valid S1 so stale operands never leak.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            result_r   <= {WIDTH{1'b0}};
        end else if (move_s) begin
            s2_valid_r <= 1'b1;
            result_r   <= result_s;
        end else if (out_fire_s) begin
            s2_valid_r <= 1'b0;
        end
    end

    // Completed-transfer counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (out_fire_s) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

`ifdef BITWISE_LOGIC_FLAGS_EN
    logic zero_r;
    logic ones_r;
    logic parity_r;

    // Flags share the load condition of result_r, so they hold with it while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_r   <= 1'b0;
            ones_r   <= 1'b0;
            parity_r <= 1'b0;
        end else if (move_s) begin
            zero_r   <= (result_s == {WIDTH{1'b0}});
            ones_r   <= (result_s == {WIDTH{1'b1}});
            parity_r <= parity_of(result_s);
        end
    end

    assign out_zero   = zero_r;
    assign out_ones   = ones_r;
    assign out_parity = parity_r;
`else
    assign out_zero   = 1'b0;
    assign out_ones   = 1'b0;
    assign out_parity = 1'b0;
`endif

    assign out_valid  = s2_valid_r;
    assign out_result = result_r;
    assign op_count   = count_r;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard bench for bitwise_logic_pipe (WIDTH=32, CNT_W=4); flag expectations
// follow BITWISE_LOGIC_FLAGS_EN.
module tb_bitwise_logic_pipe;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        o;
        logic        p;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_ones;
    logic        out_parity;
    logic [3:0]  op_count;

    int          checks = 0;
    int          errors = 0;
    int          fired = 0;
    logic [3:0]  exp_count = 4'd0;
    exp_t        sb[$];
    logic        acc_s;
    logic        rdy_seen;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res = 32'd0;
    logic [2:0]  prev_flags = 3'd0;
    int          idx;
    int          f0;
    logic [31:0] bp_a [4] = '{32'h1111_2222, 32'hDEAD_BEEF, 32'h0000_FFFF, 32'h8000_0001};
    logic [2:0]  bp_op [4] = '{3'd1, 3'd0, 3'd6, 3'd3};

    bitwise_logic_pipe #(.WIDTH(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero),
        .out_ones(out_ones), .out_parity(out_parity), .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        exp_t e;
        case (op)
            3'd0:    e.r = ~a;
            3'd1:    e.r = a & b;
            3'd2:    e.r = a | b;
            3'd3:    e.r = a ^ b;
            3'd4:    e.r = ~(a & b);
            3'd5:    e.r = ~(a | b);
            3'd6:    e.r = ~(a ^ b);
            default: e.r = a;
        endcase
`ifdef BITWISE_LOGIC_FLAGS_EN
        e.z = (e.r == 32'h0000_0000);
        e.o = (e.r == 32'hFFFF_FFFF);
        e.p = ^e.r;
`else
        e.z = 1'b0;
        e.o = 1'b0;
        e.p = 1'b0;
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, account transfers before the edge, check counter after it.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic ordy);
        exp_t e;
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b; in_op = op; out_ready = ordy;
        #1;
        rdy_seen = in_ready;
        acc_s = in_valid && in_ready;
        if (prev_stall) begin
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_result", {32'd0, out_result}, {32'd0, prev_res});
            chk("hold_flags", {61'd0, out_zero, out_ones, out_parity}, {61'd0, prev_flags});
        end
        if (out_valid && out_ready) begin
            fired++;
            if (sb.size() == 0) begin
                chk("unexpected_output", {63'd0, out_valid}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("result", {32'd0, out_result}, {32'd0, e.r});
                chk("flags", {61'd0, out_zero, out_ones, out_parity}, {61'd0, e.z, e.o, e.p});
            end
            exp_count++;
        end
        if (acc_s) sb.push_back(model(a, b, op));
        prev_stall = out_valid && !out_ready;
        prev_res   = out_result;
        prev_flags = {out_zero, out_ones, out_parity};
        @(posedge clk);
        #1;
        chk("op_count", {60'd0, op_count}, {60'd0, exp_count});
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && sb.size() != 0; i++) step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; in_op = 3'd0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_result", {32'd0, out_result}, 64'd0);
        chk("rst_flags", {61'd0, out_zero, out_ones, out_parity}, 64'd0);
        chk("rst_op_count", {60'd0, op_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Basic NOT with latency check
        step(1'b1, 32'hA5A5_A5A5, 32'd0, 3'd0, 1'b1);
        chk("lat_cycle1_valid", {63'd0, out_valid}, 64'd0);
        step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
        chk("lat_cycle2_valid", {63'd0, out_valid}, 64'd1);
        chk("not_result", {32'd0, out_result}, 64'h5A5A_5A5A);
        step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
        chk("not_count", {60'd0, op_count}, 64'd1);

        // All ops back-to-back: eight results in ten cycles
        f0 = fired;
        for (int i = 0; i < 10; i++)
            step(i < 8, 32'hF0F0_00FF, 32'hFF00_0F0F, 3'(i), 1'b1);
        chk("sweep_burst", 64'(fired - f0), 64'd8);
        chk("sweep_empty", 64'(sb.size()), 64'd0);

        // Flag corners
        step(1'b1, 32'h1234_5678, 32'h1234_5678, 3'd3, 1'b1);
        step(1'b1, 32'd0, 32'd0, 3'd5, 1'b1);
        step(1'b1, 32'd1, 32'd0, 3'd7, 1'b1);
        drain(6);

        // Backpressure: two accepted, then in_ready low, then release
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, bp_a[idx % 4], ~bp_a[idx % 4], bp_op[idx % 4], 1'b0);
            if (acc_s) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'd2);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            step(idx < 4, bp_a[idx % 4], ~bp_a[idx % 4], bp_op[idx % 4], 1'b1);
            if (i == 0) chk("bp_in_ready_rise", {63'd0, rdy_seen}, 64'd1);
            if (acc_s) idx++;
        end
        chk("bp_all_accepted", 64'(idx), 64'd4);
        chk("bp_empty", 64'(sb.size()), 64'd0);

        // 17th transfer wraps the 4-bit counter to 1
        step(1'b1, 32'hCAFE_0000, 32'h0000_CAFE, 3'd2, 1'b1);
        drain(4);
        chk("wrap_count", {60'd0, op_count}, 64'd1);

        // Reset while both stages hold data
        step(1'b1, 32'h0BAD_0001, 32'd0, 3'd7, 1'b0);
        step(1'b1, 32'h0BAD_0002, 32'd0, 3'd7, 1'b0);
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("async_rst_count", {60'd0, op_count}, 64'd0);
        chk("async_rst_in_ready", {63'd0, in_ready}, 64'd1);
        sb.delete();
        exp_count = 4'd0;
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
            chk("no_stale_valid", {63'd0, out_valid}, 64'd0);
        end
        step(1'b1, 32'h3C3C_0F0F, 32'hFFFF_0000, 3'd4, 1'b1);
        chk("post_rst_c1_valid", {63'd0, out_valid}, 64'd0);
        step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
        chk("post_rst_c2_valid", {63'd0, out_valid}, 64'd1);
        step(1'b0, 32'd0, 32'd0, 3'd0, 1'b1);
        chk("post_rst_count", {60'd0, op_count}, 64'd1);
        drain(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
